mem_arbiter: RTL

Two-port arbiter and access sequencer placed in front of the single-port, word-organised `memory` block. It shares the memory between the instruction-fetch port and the load/store data port. It converts sized data accesses into word-aligned memory transactions, replicating write data and generating byte enables for stores, and extracting and sign/zero-extending loaded data. Only one transaction is in flight at a time, and a starvation counter bounds how long data traffic can block fetch.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, mem_arbiter and the single-port memory.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [1:0]  d_req_size;
    logic        d_req_unsigned;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  i_req_valid, i_req_addr, i_rsp_ready,
        input  d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata, d_rsp_ready,
        input  mem_read_data,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_address, mem_write_data, mem_byte_enable, mem_write_enable
    );

    modport master (
        output i_req_valid, i_req_addr, i_rsp_ready,
        output d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata, d_rsp_ready,
        output mem_read_data,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_address, mem_write_data, mem_byte_enable, mem_write_enable
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sized-access sequencer for the single-port word memory.
// Optional macro MEM_ARB_MISALIGN_TRAP_EN: trap misaligned accesses with err=1 and no memory access.
module mem_arbiter #(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    state_t      r_state;
    logic [3:0]  r_streak;
    logic        r_port_d_p0;
    logic        r_we_p0;
    logic        r_uns_p0;
    logic        r_mis_p0;
    logic [1:0]  r_lo_p0;
    logic [1:0]  r_size_p0;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_mem_we;
    logic        r_i_rsp_valid;
    logic        r_d_rsp_valid;
    logic [31:0] r_i_rsp_data;
    logic [31:0] r_d_rsp_data;
    logic        r_i_rsp_err;
    logic        r_d_rsp_err;

    logic        w_idle;
    logic        w_d_grant;
    logic        w_i_grant;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_we;
    logic        w_mis;

    function automatic logic [3:0] f_byte_en(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] wdata, input logic [1:0] size);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Lane select plus sign/zero extension of the word read back from memory.
    function automatic logic [31:0] f_load(input logic [31:0] rdata, input logic [1:0] lo,
                                           input logic [1:0] size, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    function automatic logic f_misaligned(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction
`endif

    // Data wins unless fetch has waited through a full streak of data grants.
    assign w_idle    = (r_state == IDLE) && nrst;
    assign w_d_grant = w_idle && bus.d_req_valid && !(bus.i_req_valid && (r_streak == STREAK_MAX));
    assign w_i_grant = w_idle && bus.i_req_valid && !w_d_grant;

    assign w_addr = w_d_grant ? bus.d_req_addr : bus.i_req_addr;
    assign w_size = w_d_grant ? bus.d_req_size : 2'b10;
    assign w_we   = w_d_grant && bus.d_req_we;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    assign w_mis  = f_misaligned(w_addr[1:0], w_size);
`else
    assign w_mis  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state       <= IDLE;
            r_streak      <= 4'd0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_be      <= 4'h0;
            r_mem_we      <= 1'b0;
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_i_rsp_data  <= 32'h0;
            r_d_rsp_data  <= 32'h0;
            r_i_rsp_err   <= 1'b0;
            r_d_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                // IDLE -> ACCESS: latch request and stage the memory drive
                IDLE: begin
                    if (w_d_grant || w_i_grant) begin
                        r_port_d_p0 <= w_d_grant;
                        r_we_p0     <= w_we;
                        r_uns_p0    <= w_d_grant && bus.d_req_unsigned;
                        r_mis_p0    <= w_mis;
                        r_lo_p0     <= w_addr[1:0];
                        r_size_p0   <= w_size;
                        r_mem_addr  <= w_mis ? 32'h0 : {w_addr[31:2], 2'b00};
                        r_mem_be    <= w_mis ? 4'h0 : f_byte_en(w_addr[1:0], w_size);
                        r_mem_wdata <= (w_mis || !w_d_grant) ? 32'h0 : f_wdata(bus.d_req_wdata, w_size);
                        r_mem_we    <= w_we && !w_mis;
                        r_state     <= ACCESS;
                        if (w_i_grant || !bus.i_req_valid)
                            r_streak <= 4'd0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 4'd1;
                    end
                end
                // ACCESS -> RESP: capture read data into the response registers
                ACCESS: begin
                    r_mem_addr  <= 32'h0;
                    r_mem_wdata <= 32'h0;
                    r_mem_be    <= 4'h0;
                    r_mem_we    <= 1'b0;
                    if (r_port_d_p0) begin
                        r_d_rsp_valid <= 1'b1;
                        r_d_rsp_err   <= r_mis_p0;
                        r_d_rsp_data  <= (r_mis_p0 || r_we_p0) ? 32'h0 :
                                         f_load(bus.mem_read_data, r_lo_p0, r_size_p0, r_uns_p0);
                    end else begin
                        r_i_rsp_valid <= 1'b1;
                        r_i_rsp_err   <= r_mis_p0;
                        r_i_rsp_data  <= r_mis_p0 ? 32'h0 : bus.mem_read_data;
                    end
                    r_state <= RESP;
                end
                // RESP -> IDLE: wait for the owning port to consume
                RESP: begin
                    if (r_port_d_p0 ? bus.d_rsp_ready : bus.i_rsp_ready) begin
                        r_i_rsp_valid <= 1'b0;
                        r_d_rsp_valid <= 1'b0;
                        r_i_rsp_data  <= 32'h0;
                        r_d_rsp_data  <= 32'h0;
                        r_i_rsp_err   <= 1'b0;
                        r_d_rsp_err   <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_req_ready      = w_i_grant;
    assign bus.d_req_ready      = w_d_grant;
    assign bus.i_rsp_valid      = r_i_rsp_valid;
    assign bus.i_rsp_data       = r_i_rsp_data;
    assign bus.i_rsp_err        = r_i_rsp_err;
    assign bus.d_rsp_valid      = r_d_rsp_valid;
    assign bus.d_rsp_data       = r_d_rsp_data;
    assign bus.d_rsp_err        = r_d_rsp_err;
    assign bus.mem_address      = r_mem_addr;
    assign bus.mem_write_data   = r_mem_wdata;
    assign bus.mem_byte_enable  = r_mem_be;
    // Reset kills a store strobe in the same cycle it is asserted.
    assign bus.mem_write_enable = r_mem_we && nrst;
endmodule
